// File: rtl/slv_axi4_to_axilite_rd_pkg.sv
// Shared encodings for the slave-side AXI4 -> AXI4-Lite read converter:
// burst types, response codes, FSM states and the supported-size helper.
package slv_axi4_to_axilite_rd_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  // Largest AxSIZE a data bus of width dw can carry in one beat.
  function automatic logic [2:0] max_axsize(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/slv_axi4_to_axilite_rd_if.sv
// Bus bundle for the read converter: crossbar-side AXI4 AR/R plus the
// AXI4-Lite AR/R towards the slave. The converter uses the slave modport.
interface slv_axi4_to_axilite_rd_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 32
);

  logic [ID_WIDTH-1:0]   slaveARID;
  logic [ADDR_WIDTH-1:0] slaveARADDR;
  logic [7:0]            slaveARLEN;
  logic [2:0]            slaveARSIZE;
  logic [1:0]            slaveARBURST;
  logic                  slaveARVALID;
  logic                  slaveARREADY;
  logic [ID_WIDTH-1:0]   slaveRID;
  logic [DATA_WIDTH-1:0] slaveRDATA;
  logic [1:0]            slaveRRESP;
  logic                  slaveRLAST;
  logic                  slaveRVALID;
  logic                  slaveRREADY;
  logic [ADDR_WIDTH-1:0] LITE_ARADDR;
  logic                  LITE_ARVALID;
  logic                  LITE_ARREADY;
  logic [DATA_WIDTH-1:0] LITE_RDATA;
  logic [1:0]            LITE_RRESP;
  logic                  LITE_RVALID;
  logic                  LITE_RREADY;

  modport slave (
    input  slaveARID, slaveARADDR, slaveARLEN, slaveARSIZE, slaveARBURST,
    input  slaveARVALID, slaveRREADY,
    input  LITE_ARREADY, LITE_RDATA, LITE_RRESP, LITE_RVALID,
    output slaveARREADY, slaveRID, slaveRDATA, slaveRRESP, slaveRLAST, slaveRVALID,
    output LITE_ARADDR, LITE_ARVALID, LITE_RREADY
  );

  modport master (
    output slaveARID, slaveARADDR, slaveARLEN, slaveARSIZE, slaveARBURST,
    output slaveARVALID, slaveRREADY,
    output LITE_ARREADY, LITE_RDATA, LITE_RRESP, LITE_RVALID,
    input  slaveARREADY, slaveRID, slaveRDATA, slaveRRESP, slaveRLAST, slaveRVALID,
    input  LITE_ARADDR, LITE_ARVALID, LITE_RREADY
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address stepper: from the current beat address
// computes the next one for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
  import slv_axi4_to_axilite_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 20
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  burst_e                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] bytes_s;
  logic [ADDR_WIDTH-1:0] wrap_mask_s;
  logic [ADDR_WIDTH-1:0] incr_addr_s;

  // INCR realigns to the beat size so only the first beat can be unaligned.
  always_comb begin
    bytes_s     = ADDR_WIDTH'(1'b1) << size;
    wrap_mask_s = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1'b1)) << size) - ADDR_WIDTH'(1'b1);
    incr_addr_s = (cur_addr & ~(bytes_s - ADDR_WIDTH'(1'b1))) + bytes_s;
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask_s) | ((cur_addr + bytes_s) & wrap_mask_s);
      default:     next_addr = incr_addr_s;
    endcase
  end

endmodule

// File: rtl/slv_axi4_to_axilite_rd.sv
// Slave-side read converter: splits one AXI4 read burst at a time into
// single-beat AXI4-Lite reads and rebuilds RID/RLAST on the AXI4 side.
module slv_axi4_to_axilite_rd
  import slv_axi4_to_axilite_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           SLV_CLK,
  input  logic                           sysReset,
  slv_axi4_to_axilite_rd_if.slave        bus
);

  localparam logic [2:0] MAX_SIZE = max_axsize(DATA_WIDTH);

  state_e                state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  arvalid_q, arvalid_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  burst_e                burst_q, burst_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;

  logic                  ar_hs_s;
  logic                  lite_ar_hs_s;
  logic                  lite_r_hs_s;
  logic                  out_free_s;
  logic                  lite_rready_s;
  logic                  size_err_s;
  logic                  last_beat_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;

  assign ar_hs_s       = bus.slaveARVALID && arready_q;
  assign out_free_s    = !rvalid_q || bus.slaveRREADY;
  assign lite_rready_s = (state_q == ST_DATA) && out_free_s;
  assign lite_ar_hs_s  = arvalid_q && bus.LITE_ARREADY;
  assign lite_r_hs_s   = bus.LITE_RVALID && lite_rready_s;
  assign size_err_s    = bus.slaveARSIZE > MAX_SIZE;
  assign last_beat_s   = (cnt_q == 8'd0);

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .cur_addr  (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr_s)
  );

  // FSM state register.
  always_ff @(posedge SLV_CLK or negedge sysReset) begin
    if (!sysReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs_s) begin
          state_d = size_err_s ? ST_ERR : ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (lite_ar_hs_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (lite_r_hs_s) begin
          state_d = last_beat_s ? ST_IDLE : ST_ADDR;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_ERR: begin
        if (out_free_s && last_beat_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; the R register reloads only when free.
  always_comb begin
    arready_d = (state_d == ST_IDLE);
    arvalid_d = (state_d == ST_ADDR);
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    rvalid_d  = rvalid_q && !bus.slaveRREADY;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs_s) begin
          id_d    = bus.slaveARID;
          addr_d  = bus.slaveARADDR;
          len_d   = bus.slaveARLEN;
          size_d  = bus.slaveARSIZE;
          burst_d = burst_e'(bus.slaveARBURST);
          cnt_d   = bus.slaveARLEN;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DATA: begin
        if (lite_r_hs_s) begin
          rvalid_d = 1'b1;
          rdata_d  = bus.LITE_RDATA;
          rresp_d  = bus.LITE_RRESP;
          rid_d    = id_q;
          rlast_d  = last_beat_s;
          if (!last_beat_s) begin
            cnt_d  = cnt_q - 8'd1;
            addr_d = next_addr_s;
          end else begin
            cnt_d  = cnt_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ERR: begin
        if (out_free_s) begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          rid_d    = id_q;
          rlast_d  = last_beat_s;
          if (!last_beat_s) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge SLV_CLK or negedge sysReset) begin
    if (!sysReset) begin
      arready_q <= 1'b0;
      arvalid_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= BURST_FIXED;
      cnt_q     <= 8'd0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      arready_q <= arready_d;
      arvalid_q <= arvalid_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign bus.slaveARREADY = arready_q;
  assign bus.slaveRID     = rid_q;
  assign bus.slaveRDATA   = rdata_q;
  assign bus.slaveRRESP   = rresp_q;
  assign bus.slaveRLAST   = rlast_q;
  assign bus.slaveRVALID  = rvalid_q;
  assign bus.LITE_ARADDR  = addr_q;
  assign bus.LITE_ARVALID = arvalid_q;
  assign bus.LITE_RREADY  = lite_rready_s;

endmodule

// File: tb/tb_slv_axi4_to_axilite_rd.sv
// Bench for slv_axi4_to_axilite_rd: random and directed bursts, a Lite slave
// with random stalls, and a queue-based scoreboard computed from burst rules.
module tb_slv_axi4_to_axilite_rd;

  localparam int AW = 20;
  localparam int IW = 1;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic sysReset;
  always #5 clk = ~clk;

  slv_axi4_to_axilite_rd_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  slv_axi4_to_axilite_rd #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .SLV_CLK  (clk),
    .sysReset (sysReset),
    .bus      (bus)
  );

  int            n_vec = 0;
  int            n_miss = 0;
  logic [AW-1:0] exp_addr_q[$];
  beat_t         exp_r_q[$];
  logic          lite_pend = 1'b0;
  logic [AW-1:0] lite_addr = '0;
  logic          ar_seen = 1'b0;
  logic          hold_prev = 1'b0;
  logic [36:0]   held = '0;
  int            r_beats = 0;
  int            lite_arv_cyc = 0;
  int            bp_left = 0;
  logic          bp_arm = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Contents of the external Lite slave, a fixed function of the address.
  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {a[11:0], a} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [AW-1:0] a);
    return (a[5:4] == 2'b11) ? a[3:2] : 2'b00;
  endfunction

  // Address of beat i of a burst, from the burst arithmetic directly.
  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input logic [2:0] sz,
                                              input logic [7:0] len, input logic [1:0] bt, input int i);
    int unsigned av, bytes, total, base;
    av    = 32'(a);
    bytes = 32'd1 << sz;
    total = (32'(len) + 32'd1) * bytes;
    if (bt == 2'b00) begin
      return a;
    end else if (bt == 2'b10) begin
      base = av - (av % total);
      return AW'(base + ((av - base + 32'(i) * bytes) % total));
    end else if (i == 0) begin
      return a;
    end else begin
      return AW'((av / bytes) * bytes + 32'(i) * bytes);
    end
  endfunction

  // One clock: observe handshakes at the falling edge, then drive after the rising edge.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (sysReset) begin
      if (bus.LITE_ARVALID) lite_arv_cyc++;
      if (bus.LITE_ARVALID && bus.LITE_ARREADY) begin
        if (exp_addr_q.size() == 0) chk("lite_ar_unexpected", 64'(bus.LITE_ARADDR), 64'hFFFF_FFFF);
        else chk("lite_araddr", 64'(bus.LITE_ARADDR), 64'(exp_addr_q.pop_front()));
        lite_pend = 1'b1;
        lite_addr = bus.LITE_ARADDR;
      end
      if (bus.LITE_RVALID && bus.LITE_RREADY) lite_pend = 1'b0;
      if (hold_prev)
        chk("r_stable", 64'({bus.slaveRVALID, bus.slaveRID, bus.slaveRDATA, bus.slaveRRESP, bus.slaveRLAST}), 64'(held));
      if (bus.slaveRVALID && !bus.slaveRREADY) chk("lite_rready_full", 64'(bus.LITE_RREADY), 64'd0);
      if (bus.slaveRVALID && bus.slaveRREADY) begin
        if (exp_r_q.size() == 0) begin
          chk("r_unexpected", 64'(bus.slaveRDATA), 64'hFFFF_FFFF_FFFF);
        end else begin
          e = exp_r_q.pop_front();
          chk("rdata", 64'(bus.slaveRDATA), 64'(e.data));
          chk("rresp", 64'(bus.slaveRRESP), 64'(e.resp));
          chk("rid",   64'(bus.slaveRID),   64'(e.id));
          chk("rlast", 64'(bus.slaveRLAST), 64'(e.last));
        end
        r_beats++;
      end
      hold_prev = bus.slaveRVALID && !bus.slaveRREADY;
      held = {1'b1, bus.slaveRID, bus.slaveRDATA, bus.slaveRRESP, bus.slaveRLAST};
      if (bus.slaveARVALID && bus.slaveARREADY) ar_seen = 1'b1;
    end else begin
      hold_prev = 1'b0;
    end
    @(posedge clk);
    #1;
    if (ar_seen) bus.slaveARVALID = 1'b0;
    bus.LITE_ARREADY = ($urandom_range(0, 3) != 0);
    if (!lite_pend) begin
      bus.LITE_RVALID = 1'b0;
    end else if (!bus.LITE_RVALID && ($urandom_range(0, 2) != 0)) begin
      bus.LITE_RVALID = 1'b1;
      bus.LITE_RDATA  = mem_data(lite_addr);
      bus.LITE_RRESP  = mem_resp(lite_addr);
    end
    if (bp_left > 0) begin
      bus.slaveRREADY = 1'b0;
      bp_left--;
    end else if (bp_arm && r_beats == 1) begin
      bus.slaveRREADY = 1'b0;
      bp_left = 4;
      bp_arm = 1'b0;
    end else begin
      bus.slaveRREADY = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send_burst(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bt);
    logic          err;
    logic [AW-1:0] ba;
    beat_t         b;
    err = (sz > 3'd2);
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, sz, len, bt, i);
      b.id   = id;
      b.last = (i == int'(len));
      if (err) begin
        b.data = '0;
        b.resp = 2'b10;
      end else begin
        exp_addr_q.push_back(ba);
        b.data = mem_data(ba);
        b.resp = mem_resp(ba);
      end
      exp_r_q.push_back(b);
    end
    bus.slaveARID    = id;
    bus.slaveARADDR  = a;
    bus.slaveARLEN   = len;
    bus.slaveARSIZE  = sz;
    bus.slaveARBURST = bt;
    bus.slaveARVALID = 1'b1;
    ar_seen = 1'b0;
    for (int g = 0; g < 2000 && !ar_seen; g++) tick();
    chk("ar_handshake", 64'(ar_seen), 64'd1);
    bus.slaveARVALID = 1'b0;
    if (ar_seen && sysReset) chk("lite_arvalid_latency", 64'(bus.LITE_ARVALID), 64'(!err));
  endtask

  task automatic drain();
    for (int g = 0; g < 6000 && exp_r_q.size() != 0; g++) tick();
    chk("drain", 64'(exp_r_q.size()), 64'd0);
  endtask

  initial begin
    logic [1:0]    bt;
    logic [2:0]    sz;
    logic [7:0]    len;
    logic [AW-1:0] a;

    sysReset = 1'b0;
    bus.slaveARID = '0;  bus.slaveARADDR = '0; bus.slaveARLEN = 8'd0;
    bus.slaveARSIZE = 3'd0; bus.slaveARBURST = 2'b00; bus.slaveARVALID = 1'b0;
    bus.slaveRREADY = 1'b0; bus.LITE_ARREADY = 1'b0; bus.LITE_RDATA = '0;
    bus.LITE_RRESP = 2'b00; bus.LITE_RVALID = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready",  64'(bus.slaveARREADY), 64'd0);
    chk("rst_rvalid",   64'(bus.slaveRVALID),  64'd0);
    chk("rst_arvalid",  64'(bus.LITE_ARVALID), 64'd0);
    chk("rst_rready",   64'(bus.LITE_RREADY),  64'd0);
    chk("rst_payload",  64'({bus.slaveRID, bus.slaveRDATA, bus.slaveRRESP, bus.slaveRLAST}), 64'd0);
    sysReset = 1'b1;
    tick();
    chk("arready_after_rst", 64'(bus.slaveARREADY), 64'd1);

    send_burst(1'b1, 20'h00100, 8'd3, 3'd2, 2'b01);
    send_burst(1'b0, 20'h00108, 8'd3, 3'd2, 2'b10);
    send_burst(1'b1, 20'h00020, 8'd1, 3'd2, 2'b00);
    send_burst(1'b0, 20'h00102, 8'd1, 3'd2, 2'b01);
    drain();

    r_beats = 0;
    bp_arm = 1'b1;
    send_burst(1'b1, 20'h00200, 8'd7, 3'd2, 2'b01);
    drain();

    lite_arv_cyc = 0;
    send_burst(1'b0, 20'h00300, 8'd2, 3'd3, 2'b01);
    drain();
    chk("err_no_lite_ar", 64'(lite_arv_cyc), 64'd0);
    tick();
    chk("err_arready", 64'(bus.slaveARREADY), 64'd1);

    send_burst(1'b1, 20'hFFF00, 8'd255, 3'd2, 2'b01);
    drain();

    for (int n = 0; n < 40; n++) begin
      bt  = 2'($urandom_range(0, 3));
      sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      len = (bt == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 12));
      a   = AW'($urandom_range(0, 20'hFFFFF));
      if (bt == 2'b10) a = a & ~(AW'((1 << sz) - 1));
      repeat ($urandom_range(0, 2)) tick();
      send_burst(IW'($urandom_range(0, 1)), a, len, sz, bt);
    end
    drain();

    r_beats = 0;
    send_burst(1'b0, 20'h00400, 8'd7, 3'd2, 2'b01);
    for (int g = 0; g < 1000 && r_beats < 2; g++) tick();
    chk("reset_test_reach", 64'(r_beats), 64'd2);
    sysReset = 1'b0;
    #1;
    chk("midrst_rvalid",  64'(bus.slaveRVALID),  64'd0);
    chk("midrst_arvalid", 64'(bus.LITE_ARVALID), 64'd0);
    chk("midrst_rready",  64'(bus.LITE_RREADY),  64'd0);
    chk("midrst_arready", 64'(bus.slaveARREADY), 64'd0);
    exp_addr_q.delete();
    exp_r_q.delete();
    lite_pend = 1'b0;
    bus.LITE_RVALID = 1'b0;
    bp_left = 0;
    tick();
    tick();
    sysReset = 1'b1;
    chk("release_arready_low", 64'(bus.slaveARREADY), 64'd0);
    tick();
    chk("release_arready_high", 64'(bus.slaveARREADY), 64'd1);
    send_burst(1'b1, 20'h00500, 8'd0, 3'd2, 2'b01);
    drain();
    chk("addr_queue_empty", 64'(exp_addr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
